// File: rtl/seg_display_ctrl_pkg.sv
// Shared definitions for the seven-segment display controller: register map,
// CTRL bit positions, segment patterns and the FSM/mode encodings.
package seg_display_ctrl_pkg;

  localparam logic [1:0] SEG_DATA = 2'd0;
  localparam logic [1:0] SEG_CTRL = 2'd1;

  localparam int CTRL_MODE_BIT  = 0;
  localparam int CTRL_BLANK_BIT = 1;
  localparam int CTRL_MASK_LSB  = 8;
  localparam int CTRL_MASK_MSB  = 15;

  // Segment order is {a,b,c,d,e,f,g,dp}; dp is never driven.
  localparam logic [7:0] SEG_DASH = 8'b0000_0010;
  localparam logic [7:0] SEG_OFF  = 8'b0000_0000;

  typedef enum logic {
    MODE_HEX = 1'b0,
    MODE_DEC = 1'b1
  } disp_mode_e;

  typedef enum logic {
    CONV_IDLE = 1'b0,
    CONV_RUN  = 1'b1
  } conv_state_e;

  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0: pat = 8'b1111_1100;
      4'h1: pat = 8'b0110_0000;
      4'h2: pat = 8'b1101_1010;
      4'h3: pat = 8'b1111_0010;
      4'h4: pat = 8'b0110_0110;
      4'h5: pat = 8'b1011_0110;
      4'h6: pat = 8'b1011_1110;
      4'h7: pat = 8'b1110_0000;
      4'h8: pat = 8'b1111_1110;
      4'h9: pat = 8'b1111_0110;
      4'hA: pat = 8'b1110_1110;
      4'hB: pat = 8'b0011_1110;
      4'hC: pat = 8'b1001_1100;
      4'hD: pat = 8'b0111_1010;
      4'hE: pat = 8'b1001_1110;
      default: pat = 8'b1000_1110;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Write-only register bus from the memory/IO address decoder into the
// seven-segment controller.
interface seg_display_ctrl_if;
  logic        seg_ctrl;
  logic [1:0]  addr;
  logic [31:0] wdata;

  modport master (output seg_ctrl, addr, wdata);
  modport slave  (input  seg_ctrl, addr, wdata);
endinterface

// File: rtl/seg_display_ctrl_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: 32 iterations, one per
// clock, restartable by start_i and cancellable by abort_i.
module bin2bcd_seq
  import seg_display_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] value_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [39:0] bcd_o
);

  conv_state_e state_q;
  logic [4:0]  iter_q;
  logic [31:0] bin_q;
  logic [39:0] bcd_q;

  logic [39:0] bcd_adj;
  logic [71:0] shifted_d;
  logic        last_iter;

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                  bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
    end
  endgenerate

  assign shifted_d = {bcd_adj, bin_q} << 1;
  assign last_iter = (iter_q == 5'd31);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CONV_IDLE;
      iter_q  <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
    end else if (start_i) begin
      // A start always wins, including over a conversion already running.
      state_q <= CONV_RUN;
      iter_q  <= '0;
      bin_q   <= value_i;
      bcd_q   <= '0;
    end else if (abort_i) begin
      state_q <= CONV_IDLE;
    end else if (state_q == CONV_RUN) begin
      bin_q  <= shifted_d[31:0];
      bcd_q  <= shifted_d[71:32];
      iter_q <= iter_q + 5'd1;
      if (last_iter) begin
        state_q <= CONV_IDLE;
      end
    end
  end

  assign busy_o = (state_q == CONV_RUN);
  assign done_o = (state_q == CONV_RUN) && last_iter && !start_i && !abort_i;
  // Valid while done_o is high: the result of the final iteration.
  assign bcd_o  = shifted_d[71:32];

endmodule

// File: rtl/seg_display_ctrl.sv
// Memory-mapped 8-digit seven-segment controller: DATA/CTRL registers, optional
// decimal conversion, and time-multiplexed digit scanning with registered pins.
module seg_display_ctrl
  import seg_display_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg_display_ctrl_if.slave    bus,
  output logic [7:0]           seg_en,
  output logic [7:0]           seg_out,
  output logic                 conv_busy
);

  logic [31:0] data_q;
  disp_mode_e  mode_q;
  logic        blank_q;
  logic [7:0]  mask_q;
  logic [31:0] buf_q;
  logic        ovf_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]  digit_q;
  logic [7:0]  seg_en_q;
  logic [7:0]  seg_out_q;

  logic        wr_data, wr_ctrl;
  disp_mode_e  new_mode;
  logic        conv_start, conv_abort, conv_done;
  logic [31:0] conv_value;
  logic [39:0] conv_bcd;

  assign wr_data    = bus.seg_ctrl && (bus.addr == SEG_DATA);
  assign wr_ctrl    = bus.seg_ctrl && (bus.addr == SEG_CTRL);
  assign new_mode   = disp_mode_e'(bus.wdata[CTRL_MODE_BIT]);
  assign conv_start = (wr_data && mode_q == MODE_DEC) ||
                      (wr_ctrl && new_mode == MODE_DEC && mode_q == MODE_HEX);
  assign conv_abort = wr_ctrl && new_mode == MODE_HEX && mode_q == MODE_DEC;
  // A DATA write converts the value being written, not the stale register.
  assign conv_value = wr_data ? bus.wdata : data_q;

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (conv_start),
    .abort_i (conv_abort),
    .value_i (conv_value),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      mode_q  <= MODE_HEX;
      blank_q <= 1'b0;
      mask_q  <= 8'hFF;
      buf_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_data) begin
        data_q <= bus.wdata;
      end
      if (wr_ctrl) begin
        mode_q  <= new_mode;
        blank_q <= bus.wdata[CTRL_BLANK_BIT];
        mask_q  <= bus.wdata[CTRL_MASK_MSB:CTRL_MASK_LSB];
      end
      // Decimal mode only touches the buffer on completion, so partial
      // conversions never reach the pins.
      if (mode_q == MODE_HEX) begin
        buf_q <= data_q;
        ovf_q <= 1'b0;
      end else if (conv_done) begin
        buf_q <= conv_bcd[31:0];
        ovf_q <= |conv_bcd[39:32];
      end
    end
  end

  // upper_zero[i]: digit i and every digit above it are zero.
  logic [7:0] upper_zero;
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_zero
      assign upper_zero[gi] = ~|buf_q[31:4*gi];
    end
  endgenerate

  logic [3:0] slot_nib;
  logic       slot_suppress, slot_lit;
  logic [7:0] slot_pat, slot_en, slot_seg;

  always_comb begin
    slot_nib      = buf_q[{digit_q, 2'b00} +: 4];
    slot_suppress = (mode_q == MODE_DEC) && !ovf_q && (digit_q != 3'd0) &&
                    upper_zero[digit_q];
    slot_lit      = !blank_q && mask_q[digit_q] && !slot_suppress;
    slot_pat      = ((mode_q == MODE_DEC) && ovf_q) ? SEG_DASH : hex_seg(slot_nib);
    slot_en       = slot_lit ? (8'h01 << digit_q) : SEG_OFF;
    slot_seg      = slot_lit ? slot_pat : SEG_OFF;
  end

  // Enables and segments are latched on the same wrap edge to avoid ghosting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      digit_q   <= '0;
      seg_en_q  <= SEG_OFF;
      seg_out_q <= SEG_OFF;
    end else if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_q     <= '0;
      digit_q   <= digit_q + 3'd1;
      seg_en_q  <= slot_en;
      seg_out_q <= slot_seg;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign seg_en  = seg_en_q;
  assign seg_out = seg_out_q;

endmodule
